// File: rtl/hazard_pkg.sv
// Shared defaults and scoreboard entry type for the forwarding / load-use unit.
package hazard_pkg;
    localparam int HZ_AW         = 5;
    localparam int HZ_DW         = 32;
    localparam int HZ_LOAD_READY = 1;

    typedef struct packed {
        logic              valid;
        logic              load;
        logic [HZ_AW-1:0]  wra;
    } sb_entry_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight destinations, one entry per stage after decode.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int AW    = HZ_AW
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      hold,
    input  logic                      ins_valid,
    input  logic                      ins_load,
    input  logic [AW-1:0]             ins_wra,
    output logic [DEPTH-1:0]          valid,
    output logic [DEPTH-1:0]          load,
    output logic [DEPTH-1:0][AW-1:0]  wra
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= '0;
            load  <= '0;
            wra   <= '0;
        end else if (!hold) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                valid[k] <= valid[k-1];
                load[k]  <= load[k-1];
                wra[k]   <= wra[k-1];
            end
            // A bubble is written as an all-zero entry.
            valid[0] <= ins_valid;
            load[0]  <= ins_valid & ins_load;
            wra[0]   <= ins_valid ? ins_wra : '0;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Decode-side operand forwarding with load-use stall detection and stall counter.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int N_RD       = 2,
    parameter int DEPTH      = 3,
    parameter int AW         = HZ_AW,
    parameter int DW         = HZ_DW,
    parameter int LOAD_READY = HZ_LOAD_READY
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_issue_valid,
    input  logic                  i_issue_wen,
    input  logic                  i_issue_load,
    input  logic [AW-1:0]         i_issue_wra,
    input  logic                  i_flush,
    input  logic                  i_hold,
    input  logic [N_RD*AW-1:0]    i_ra,
    input  logic [N_RD*DW-1:0]    i_rd,
    input  logic [DEPTH*DW-1:0]   i_stage_data,
    output logic [N_RD*DW-1:0]    o_rd,
    output logic [N_RD-1:0]       o_fwd_hit,
    output logic                  o_stall,
    output logic [31:0]           o_stall_cnt
);

    logic [DEPTH-1:0]         sb_valid;
    logic [DEPTH-1:0]         sb_load;
    logic [DEPTH-1:0][AW-1:0] sb_wra;
    logic [N_RD-1:0]          blocked;
    logic                     found;
    logic                     ins_valid;

    assign ins_valid = i_issue_valid & i_issue_wen & ~o_stall & ~i_flush;

    hazard_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .rstn      (rstn),
        .hold      (i_hold),
        .ins_valid (ins_valid),
        .ins_load  (i_issue_load),
        .ins_wra   (i_issue_wra),
        .valid     (sb_valid),
        .load      (sb_load),
        .wra       (sb_wra)
    );

    // Scan from the youngest stage; the first match owns the port.
    always_comb begin
        o_rd      = i_rd;
        o_fwd_hit = '0;
        blocked   = '0;
        found     = 1'b0;
        for (int p = 0; p < N_RD; p++) begin
            found = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && sb_valid[k] && (sb_wra[k] != '0)
                    && (sb_wra[k] == i_ra[p*AW +: AW])) begin
                    found = 1'b1;
                    if (sb_load[k] && (k < LOAD_READY)) begin
                        blocked[p] = 1'b1;
                    end else begin
                        o_rd[p*DW +: DW] = i_stage_data[k*DW +: DW];
                        o_fwd_hit[p]     = 1'b1;
                    end
                end
            end
        end
    end

    assign o_stall = (|blocked) & i_issue_valid & ~i_flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_stall_cnt <= '0;
        end else if (o_stall && !i_hold && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed scenarios plus randomized traffic against a behavioural scoreboard model.
module tb_hazard_fwd_unit;
    import hazard_pkg::*;

    localparam int N_RD       = 2;
    localparam int DEPTH      = 3;
    localparam int AW         = 5;
    localparam int DW         = 32;
    localparam int LOAD_READY = 1;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 i_issue_valid, i_issue_wen, i_issue_load;
    logic [AW-1:0]        i_issue_wra;
    logic                 i_flush, i_hold;
    logic [N_RD*AW-1:0]   i_ra;
    logic [N_RD*DW-1:0]   i_rd;
    logic [DEPTH*DW-1:0]  i_stage_data;
    logic [N_RD*DW-1:0]   o_rd;
    logic [N_RD-1:0]      o_fwd_hit;
    logic                 o_stall;
    logic [31:0]          o_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    sb_entry_t   m_sb [DEPTH];
    logic [31:0] m_cnt;

    hazard_fwd_unit #(
        .N_RD(N_RD), .DEPTH(DEPTH), .AW(AW), .DW(DW), .LOAD_READY(LOAD_READY)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_issue_valid(i_issue_valid),
        .i_issue_wen  (i_issue_wen),
        .i_issue_load (i_issue_load),
        .i_issue_wra  (i_issue_wra),
        .i_flush      (i_flush),
        .i_hold       (i_hold),
        .i_ra         (i_ra),
        .i_rd         (i_rd),
        .i_stage_data (i_stage_data),
        .o_rd         (o_rd),
        .o_fwd_hit    (o_fwd_hit),
        .o_stall      (o_stall),
        .o_stall_cnt  (o_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest producer wins: walk oldest to youngest and let later hits overwrite.
    function automatic void model_out(output logic [N_RD*DW-1:0] rd,
                                      output logic [N_RD-1:0] hit,
                                      output logic stall);
        logic          blk;
        logic [AW-1:0] ra;
        int            prod;
        rd  = i_rd;
        hit = '0;
        blk = 1'b0;
        for (int p = 0; p < N_RD; p++) begin
            ra   = i_ra[p*AW +: AW];
            prod = -1;
            for (int k = DEPTH - 1; k >= 0; k--)
                if (m_sb[k].valid && ra != 0 && m_sb[k].wra == ra) prod = k;
            if (prod >= 0) begin
                if (m_sb[prod].load && prod < LOAD_READY) blk = 1'b1;
                else begin
                    rd[p*DW +: DW] = i_stage_data[prod*DW +: DW];
                    hit[p]         = 1'b1;
                end
            end
        end
        stall = blk && i_issue_valid && !i_flush;
    endfunction

    always @(negedge rstn) begin
        for (int k = 0; k < DEPTH; k++) m_sb[k] = '0;
        m_cnt = 32'd0;
    end

    always @(posedge clk) begin
        logic [N_RD*DW-1:0] e_rd;
        logic [N_RD-1:0]    e_hit;
        logic               e_stall;
        if (rstn) begin
            model_out(e_rd, e_hit, e_stall);
            if (!i_hold) begin
                if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                for (int k = DEPTH - 1; k > 0; k--) m_sb[k] = m_sb[k-1];
                m_sb[0].valid = i_issue_valid && i_issue_wen && !e_stall && !i_flush;
                m_sb[0].load  = i_issue_load;
                m_sb[0].wra   = i_issue_wra;
            end
        end
    end

    always @(negedge clk) begin
        logic [N_RD*DW-1:0] c_rd;
        logic [N_RD-1:0]    c_hit;
        logic               c_stall;
        model_out(c_rd, c_hit, c_stall);
        chk("cyc_rd",    64'(o_rd),        64'(c_rd));
        chk("cyc_hit",   64'(o_fwd_hit),   64'(c_hit));
        chk("cyc_stall", 64'(o_stall),     64'(c_stall));
        chk("cyc_cnt",   64'(o_stall_cnt), 64'(m_cnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wen, input logic ld, input logic [AW-1:0] wra,
                         input logic fl, input logic hd, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        i_issue_valid = v;
        i_issue_wen   = wen;
        i_issue_load  = ld;
        i_issue_wra   = wra;
        i_flush       = fl;
        i_hold        = hd;
        i_ra          = {ra1, ra0};
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("rst_stall", 64'(o_stall),     64'd0);
        chk("rst_hit",   64'(o_fwd_hit),   64'd0);
        chk("rst_rd",    64'(o_rd),        64'(i_rd));
        chk("rst_cnt",   64'(o_stall_cnt), 64'd0);
    endtask

    initial begin
        rstn         = 1'b0;
        i_rd         = {32'h1111_0001, 32'h1111_0000};
        i_stage_data = {32'hB2B2_0002, 32'hA1A1_0001, 32'h0000_0011};
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);

        // ALU result forwarded from E
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd0, 5'd0); step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0); #1;
        chk("t1_rd0",   64'(o_rd[31:0]), 64'h11);
        chk("t1_hit",   64'(o_fwd_hit),  64'b01);
        chk("t1_stall", 64'(o_stall),    64'd0);
        step();

        // load-use: one stall cycle, then forward from M; reset mid-stall
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 5'd0); step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7); #1;
        chk("t2_stall", 64'(o_stall),      64'd1);
        chk("t2_hit",   64'(o_fwd_hit),    64'b00);
        chk("t2_rd1",   64'(o_rd[63:32]),  64'h1111_0001);
        step();
        drive(1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 5'd7); #1;
        chk("t2_stall_after", 64'(o_stall),     64'd0);
        chk("t2_hit_after",   64'(o_fwd_hit),   64'b10);
        chk("t2_rd1_after",   64'(o_rd[63:32]), 64'hA1A1_0001);
        chk("t2_cnt",         64'(o_stall_cnt), 64'd1);
        step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd8); #1;
        chk("t6_stall_pre", 64'(o_stall),     64'd1);
        chk("t6_cnt_pre",   64'(o_stall_cnt), 64'd1);
        rstn = 1'b0; #1;
        chk("t6_stall_rst", 64'(o_stall),     64'd0);
        chk("t6_cnt_rst",   64'(o_stall_cnt), 64'd0);

        // two writers of r3: the younger one wins
        do_reset();
        i_stage_data = {32'h0000_0000, 32'h0000_00AA, 32'h0000_00BB};
        drive(1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0, 5'd0); step();
        drive(1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0, 5'd0); step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd3); #1;
        chk("t3_rd", 64'(o_rd),      {32'h0000_00BB, 32'h0000_00BB});
        chk("t3_hit", 64'(o_fwd_hit), 64'b11);
        step();

        // r0 never forwards
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0); step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0); #1;
        chk("t4_hit", 64'(o_fwd_hit), 64'b00);
        chk("t4_rd",  64'(o_rd),      {32'h1111_0001, 32'h1111_0000});
        step();

        // flush beats stall, then hold freezes the scoreboard
        do_reset();
        i_stage_data = {32'hB2B2_0002, 32'hA1A1_0001, 32'hE0E0_0000};
        drive(1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 5'd0); step();
        drive(1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 5'd4, 5'd0); #1;
        chk("t5_flush_stall", 64'(o_stall), 64'd0);
        step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 5'd4); #1;
        chk("t5_bubble_hit", 64'(o_fwd_hit),   64'b10);
        chk("t5_bubble_rd1", 64'(o_rd[63:32]), 64'hA1A1_0001);
        chk("t5_cnt",        64'(o_stall_cnt), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_hold_hit", 64'(o_fwd_hit),   64'b10);
            chk("t5_hold_rd1", 64'(o_rd[63:32]), 64'hA1A1_0001);
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd4); step();
        chk("t5_release_rd1", 64'(o_rd[63:32]), 64'hB2B2_0002);

        // randomized traffic, small register range for frequent hazards
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  AW'($urandom_range(0, 7)), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            i_rd         = {$urandom, $urandom};
            i_stage_data = {$urandom, $urandom, $urandom};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised forwarding and load-use stall unit for the pipelined CPU, sitting beside the decode stage. It keeps a shift-register scoreboard of in-flight destination registers, one entry per downstream stage, with valid and load flags. For each of N_RD decode read ports it selects the youngest matching in-flight result. It raises a stall when a matching producer is a load whose data is not yet available. It adds bubble insertion, flush, global hold, register-0 exclusion and a stall counter.

## Interface
- N_RD, 2, number of decode read ports
- DEPTH, 3, tracked stages after decode (stage 0 = E, 1 = M, 2 = W)
- AW, 5, register address width
- DW, 32, data width
- LOAD_READY, 1, first stage index at which load data is valid (1 = M)
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- i_issue_valid  in  1  decode holds a real instruction
- i_issue_wen  in  1  that instruction writes a register
- i_issue_load  in  1  that instruction is a load
- i_issue_wra  in  AW  its destination register
- i_flush  in  1  kill the instruction in decode this cycle
- i_hold  in  1  global pipeline freeze; scoreboard does not shift
- i_ra  in  N_RD*AW  read addresses; port p at [p*AW +: AW]
- i_rd  in  N_RD*DW  register-file read data per port
- i_stage_data  in  DEPTH*DW  result of stage k at [k*DW +: DW]
- o_rd  out  N_RD*DW  forwarded operand per port
- o_fwd_hit  out  N_RD  port p took a forwarded value
- o_stall  out  1  load-use stall; decode must hold
- o_stall_cnt  out  32  count of stall cycles

## Operation
- Scoreboard entry: {valid, load, wra}. Reset clears all entries to 0 and sets o_stall_cnt to 0. Combinational outputs after reset: o_stall = 0, o_fwd_hit = 0, o_rd = i_rd.
- Match(p,k): entry k valid, wra != 0, wra == ra_p. Register 0 never matches.
- Per port, the smallest k with Match(p,k) is the producer. Only the youngest match counts; an older match is never used while a younger one exists.
- Producer with load = 1 and k < LOAD_READY: the port is blocked. o_rd_p = i_rd_p, o_fwd_hit_p = 0.
- Other producer: o_rd_p = i_stage_data[k], o_fwd_hit_p = 1. No producer: o_rd_p = i_rd_p, o_fwd_hit_p = 0.
- o_stall = OR of blocked over all ports, masked by i_issue_valid and forced to 0 when i_flush = 1.
- Edge update when i_hold = 0:
  - Entries shift k to k+1; entry DEPTH-1 retires.
  - Entry 0 takes {i_issue_valid & i_issue_wen & !o_stall & !i_flush, i_issue_load, i_issue_wra}.
  - When o_stall = 1 or i_flush = 1, a bubble (valid = 0) is inserted instead.
- i_hold = 1: scoreboard frozen; outputs still computed from current state.
- o_stall_cnt increments on edges with o_stall = 1 and i_hold = 0, and saturates at all-ones.

## Timing
- Forwarding and stall are combinational from registered state plus current inputs, with zero-cycle latency. No path goes from o_stall back into the match logic.
- An instruction issued at edge t occupies entry k during cycle t+k+1.
- Load followed immediately by a user, with LOAD_READY = 1: exactly one stall cycle, then the value forwards from stage 1.
- With LOAD_READY = L, the stall lasts L - k0 cycles, where k0 is the producer's current stage.
- Flush and stall in the same cycle: flush wins. o_stall = 0, bubble inserted, counter unchanged.
- Asserting reset mid-stall clears the scoreboard immediately; o_stall drops asynchronously.

## Structure
- Package hazard_pkg holds the default AW and DW, the sb_entry_t typedef {valid, load, wra} and the LOAD_READY default.
- Sub-module hazard_scoreboard contains the DEPTH-entry shift register with hold and bubble insertion. The top level holds the per-port priority match loop, the stall OR and the counter.

## Test plan
- ALU write to r5 (data 0x11), then a read of r5 on port 0 next cycle -> o_rd0 = 0x11 from stage 0, o_fwd_hit = 01, o_stall = 0.
- lw r7, then an immediate read of r7 on port 1 -> o_stall = 1 for 1 cycle, o_stall_cnt = 1; next cycle o_rd1 = stage-1 data, o_fwd_hit = 10.
- r3 written twice in succession (0xAA, then 0xBB), then a read of r3 -> 0xBB (stage 0) chosen, not 0xAA.
- Write to r0 in flight, read r0 -> o_fwd_hit = 0, o_rd = i_rd.
- lw r4 with a dependent read and i_flush = 1 in the same cycle -> o_stall = 0, bubble in entry 0, counter unchanged. i_hold = 1 for 3 cycles -> entries unchanged.
- Reset asserted during a stall -> o_stall = 0, o_stall_cnt = 0 without waiting for a clock edge.
